// File: rtl/line_pkg.sv
// Shared types and constants for the line segment scheduler: coordinate widths,
// the segment record, the commit FSM states and the endpoint range check.
package line_pkg;

    localparam int X_W     = 11;
    localparam int Y_W     = 10;
    localparam int COLOR_W = 3;

    localparam logic [X_W-1:0] HMAX_DEF = 11'd1023;
    localparam logic [Y_W-1:0] VMAX_DEF = 10'd767;

    typedef struct packed {
        logic [X_W-1:0]     x1;
        logic [Y_W-1:0]     y1;
        logic [X_W-1:0]     x2;
        logic [Y_W-1:0]     y2;
        logic [COLOR_W-1:0] color;
        logic               en;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } state_t;

    function automatic logic coords_ok(
        input logic [X_W-1:0] x1,
        input logic [X_W-1:0] x2,
        input logic [X_W-1:0] hmax,
        input logic [Y_W-1:0] y1,
        input logic [Y_W-1:0] y2,
        input logic [Y_W-1:0] vmax
    );
        return (x1 <= hmax) && (x2 <= hmax) && (y1 <= vmax) && (y2 <= vmax);
    endfunction

endpackage

// File: rtl/line_pixel_prio_mux.sv
// Registered fixed-priority merge of the engine pixels: the lowest enabled slot
// with a nonzero pixel wins, otherwise the background colour is shown.
module line_pixel_prio_mux
    import line_pkg::*;
#(
    parameter int                 NSEG     = 4,
    parameter logic [COLOR_W-1:0] BG_COLOR = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NSEG-1:0]           seg_en,
    input  logic [NSEG*COLOR_W-1:0]   eng_pixel,
    output logic [COLOR_W-1:0]        pixel
);

    logic [COLOR_W-1:0] sel_s;
    logic [COLOR_W-1:0] pixel_r;

    // Walk from the highest slot down so the lowest qualifying slot overwrites last.
    always_comb begin
        sel_s = BG_COLOR;
        for (int k = NSEG - 1; k >= 0; k--) begin
            sel_s = (seg_en[k] && (eng_pixel[k*COLOR_W +: COLOR_W] != 3'b000))
                    ? eng_pixel[k*COLOR_W +: COLOR_W] : sel_s;
        end
    end

    // Output register for the merged pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_r <= BG_COLOR;
        end else begin
            pixel_r <= sel_s;
        end
    end

    assign pixel = pixel_r;

endmodule

// File: rtl/line_segment_scheduler.sv
// Double-buffered segment table for a bank of line engines: host writes go to a
// shadow table, which is copied to the active table only at a frame boundary.
module line_segment_scheduler
    import line_pkg::*;
#(
    parameter int                 NSEG     = 4,
    parameter int                 SLOT_W   = 2,
    parameter logic [X_W-1:0]     HMAX     = 11'd1023,
    parameter logic [Y_W-1:0]     VMAX     = 10'd767,
    parameter logic [COLOR_W-1:0] BG_COLOR = 3'b000
) (
    input  logic                      vclock,
    input  logic                      rst_n,
    input  logic [X_W-1:0]            hcount,
    input  logic [Y_W-1:0]            vcount,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [SLOT_W-1:0]         wr_slot,
    input  logic [X_W-1:0]            wr_x1,
    input  logic [X_W-1:0]            wr_x2,
    input  logic [Y_W-1:0]            wr_y1,
    input  logic [Y_W-1:0]            wr_y2,
    input  logic [COLOR_W-1:0]        wr_color,
    input  logic                      wr_en,
    output logic                      wr_err,
    input  logic                      commit_valid,
    output logic                      commit_ready,
    output logic                      swap_done,
    output logic [NSEG*X_W-1:0]       seg_x1,
    output logic [NSEG*X_W-1:0]       seg_x2,
    output logic [NSEG*Y_W-1:0]       seg_y1,
    output logic [NSEG*Y_W-1:0]       seg_y2,
    output logic [NSEG*COLOR_W-1:0]   seg_color,
    output logic [NSEG-1:0]           seg_en,
    input  logic [NSEG*COLOR_W-1:0]   eng_pixel,
    output logic [COLOR_W-1:0]        pixel
);

    state_t state_r;
    logic   ready_r;
    logic   swap_done_r;
    logic   wr_err_r;
    logic   origin_d_r;
    logic   frame_start_r;
    seg_t   shadow_r [NSEG];
    seg_t   active_r [NSEG];

    logic origin_s;
    logic wr_acc_s;
    logic wr_ok_s;

    assign origin_s = (hcount == 11'd0) && (vcount == 10'd0);
    assign wr_acc_s = wr_valid && ready_r;
    assign wr_ok_s  = coords_ok(wr_x1, wr_x2, HMAX, wr_y1, wr_y2, VMAX);

    // Rising-edge detect of the raster origin so a held match gives one pulse.
    always_ff @(posedge vclock or negedge rst_n) begin
        if (!rst_n) begin
            origin_d_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            origin_d_r    <= origin_s;
            frame_start_r <= origin_s && !origin_d_r;
        end
    end

    // Shadow table writes and the rejected-write pulse.
    always_ff @(posedge vclock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                shadow_r[k] <= '0;
            end
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_acc_s && !wr_ok_s;
            if (wr_acc_s && wr_ok_s) begin
                shadow_r[wr_slot] <= '{x1: wr_x1, y1: wr_y1, x2: wr_x2, y2: wr_y2,
                                       color: wr_color, en: wr_en};
            end
        end
    end

    // Commit FSM; the active table is only loaded on the PENDING->SWAP edge.
    always_ff @(posedge vclock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            swap_done_r <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                active_r[k] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    swap_done_r <= 1'b0;
                    if (commit_valid && ready_r) begin
                        state_r <= PENDING;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end
                end
                PENDING: begin
                    ready_r <= 1'b0;
                    if (frame_start_r) begin
                        active_r    <= shadow_r;
                        state_r     <= SWAP;
                        swap_done_r <= 1'b1;
                    end else begin
                        state_r     <= PENDING;
                        swap_done_r <= 1'b0;
                    end
                end
                SWAP: begin
                    state_r     <= IDLE;
                    ready_r     <= 1'b1;
                    swap_done_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    ready_r     <= 1'b1;
                    swap_done_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_out
        assign seg_x1[k*X_W +: X_W]             = active_r[k].x1;
        assign seg_x2[k*X_W +: X_W]             = active_r[k].x2;
        assign seg_y1[k*Y_W +: Y_W]             = active_r[k].y1;
        assign seg_y2[k*Y_W +: Y_W]             = active_r[k].y2;
        assign seg_color[k*COLOR_W +: COLOR_W]  = active_r[k].color;
        assign seg_en[k]                        = active_r[k].en;
    end

    assign wr_ready     = ready_r;
    assign commit_ready = ready_r;
    assign swap_done    = swap_done_r;
    assign wr_err       = wr_err_r;

    line_pixel_prio_mux #(
        .NSEG     (NSEG),
        .BG_COLOR (BG_COLOR)
    ) u_prio_mux (
        .clk       (vclock),
        .rst_n     (rst_n),
        .seg_en    (seg_en),
        .eng_pixel (eng_pixel),
        .pixel     (pixel)
    );

endmodule

// File: tb/tb_line_segment_scheduler.sv
// Scoreboard bench: stimulus pushes expected swaps, write errors and pixels into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_line_segment_scheduler;
    import line_pkg::*;

    typedef struct packed {
        logic [43:0] x1;
        logic [43:0] x2;
        logic [39:0] y1;
        logic [39:0] y2;
        logic [11:0] color;
        logic [3:0]  en;
    } snap_t;

    logic        vclock = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        wr_valid, wr_ready, wr_en, wr_err;
    logic [1:0]  wr_slot;
    logic [10:0] wr_x1, wr_x2;
    logic [9:0]  wr_y1, wr_y2;
    logic [2:0]  wr_color;
    logic        commit_valid, commit_ready, swap_done;
    logic [43:0] seg_x1, seg_x2;
    logic [39:0] seg_y1, seg_y2;
    logic [11:0] seg_color;
    logic [3:0]  seg_en;
    logic [11:0] eng_pixel;
    logic [2:0]  pixel;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic probe   = 1'b0;
    logic probe_d = 1'b0;

    seg_t  exp_shadow [4];
    seg_t  exp_active [4];
    snap_t swap_q [$];
    int    err_q  [$];
    logic [2:0] pix_q [$];

    line_segment_scheduler dut (
        .vclock(vclock), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_y1(wr_y1), .wr_y2(wr_y2),
        .wr_color(wr_color), .wr_en(wr_en), .wr_err(wr_err),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .swap_done(swap_done),
        .seg_x1(seg_x1), .seg_x2(seg_x2), .seg_y1(seg_y1), .seg_y2(seg_y2),
        .seg_color(seg_color), .seg_en(seg_en), .eng_pixel(eng_pixel), .pixel(pixel)
    );

    always #5 vclock = ~vclock;

    always @(posedge vclock) begin
        cyc     <= cyc + 1;
        probe_d <= probe;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge vclock);
        #1;
    endtask

    function automatic snap_t pack_active();
        snap_t s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            s.x1[k*11 +: 11]  = exp_active[k].x1;
            s.x2[k*11 +: 11]  = exp_active[k].x2;
            s.y1[k*10 +: 10]  = exp_active[k].y1;
            s.y2[k*10 +: 10]  = exp_active[k].y2;
            s.color[k*3 +: 3] = exp_active[k].color;
            s.en[k]           = exp_active[k].en;
        end
        return s;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            exp_shadow[k] = '0;
            exp_active[k] = '0;
        end
    endtask

    task automatic do_write(input int slot, input int x1, input int y1, input int x2,
                            input int y2, input int color, input bit en, input bit with_commit);
        check("wr_ready_before_write", {63'd0, wr_ready}, 64'd1);
        wr_valid = 1'b1;  wr_slot = slot[1:0];
        wr_x1 = x1[10:0]; wr_y1 = y1[9:0]; wr_x2 = x2[10:0]; wr_y2 = y2[9:0];
        wr_color = color[2:0]; wr_en = en;
        commit_valid = with_commit;
        if (x1 <= 1023 && x2 <= 1023 && y1 <= 767 && y2 <= 767)
            exp_shadow[slot] = '{x1: x1[10:0], y1: y1[9:0], x2: x2[10:0], y2: y2[9:0],
                                 color: color[2:0], en: en};
        else
            err_q.push_back(cyc + 1);
        tick(1);
        wr_valid = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic do_commit();
        check("commit_ready_idle", {63'd0, commit_ready}, 64'd1);
        commit_valid = 1'b1;
        tick(1);
        commit_valid = 1'b0;
        check("commit_ready_pending", {63'd0, commit_ready}, 64'd0);
        check("wr_ready_pending", {63'd0, wr_ready}, 64'd0);
    endtask

    task automatic frame(input bit expect_swap, input int hold);
        hcount = 11'd0;
        vcount = 10'd0;
        if (expect_swap) begin
            for (int k = 0; k < 4; k++) exp_active[k] = exp_shadow[k];
            swap_q.push_back(pack_active());
        end
        tick(hold);
        hcount = 11'd5;
        vcount = 10'd200;
        tick(3);
    endtask

    task automatic probe_pixel(input logic [11:0] eng, input logic [2:0] exp);
        eng_pixel = eng;
        probe = 1'b1;
        pix_q.push_back(exp);
        tick(1);
        probe = 1'b0;
        tick(1);
    endtask

    // Monitor: pops expectations whenever the DUT presents swap_done, wr_err or a probed pixel.
    always @(negedge vclock) begin : mon
        snap_t s;
        if (rst_n) begin
            if (swap_done) begin
                if (swap_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL swap_done: got unexpected pulse at cycle %0d, expected none", cyc);
                end else begin
                    s = swap_q.pop_front();
                    check("swap_seg_x1", {20'd0, seg_x1}, {20'd0, s.x1});
                    check("swap_seg_x2", {20'd0, seg_x2}, {20'd0, s.x2});
                    check("swap_seg_y1", {24'd0, seg_y1}, {24'd0, s.y1});
                    check("swap_seg_y2", {24'd0, seg_y2}, {24'd0, s.y2});
                    check("swap_seg_color", {52'd0, seg_color}, {52'd0, s.color});
                    check("swap_seg_en", {60'd0, seg_en}, {60'd0, s.en});
                end
            end
            if (wr_err) begin
                if (err_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wr_err: got unexpected pulse at cycle %0d, expected none", cyc);
                end else begin
                    check("wr_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
                end
            end
            if (probe_d) begin
                if (pix_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pixel: got %0h with no expectation queued", pixel);
                end else begin
                    check("pixel", {61'd0, pixel}, {61'd0, pix_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; hcount = 11'd300; vcount = 10'd100;
        wr_valid = 1'b0; wr_slot = 2'd0; wr_x1 = 11'd0; wr_x2 = 11'd0;
        wr_y1 = 10'd0; wr_y2 = 10'd0; wr_color = 3'd0; wr_en = 1'b0;
        commit_valid = 1'b0; eng_pixel = 12'hFFF;
        clear_model();

        // Reset mid-frame with busy engines
        tick(3);
        check("rst_seg_en", {60'd0, seg_en}, 64'd0);
        check("rst_pixel", {61'd0, pixel}, 64'd0);
        check("rst_swap_done", {63'd0, swap_done}, 64'd0);
        check("rst_wr_err", {63'd0, wr_err}, 64'd0);
        rst_n = 1'b1;
        hcount = 11'd5; vcount = 10'd200; eng_pixel = 12'h000;
        tick(1);
        check("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        check("rst_commit_ready", {63'd0, commit_ready}, 64'd1);

        // Slot 1 write, commit mid-frame, swap at frame boundary
        do_write(1, 100, 50, 400, 300, 5, 1'b1, 1'b0);
        do_commit();
        tick(2);
        check("hold_seg_x1", {20'd0, seg_x1}, 64'd0);
        check("hold_seg_en", {60'd0, seg_en}, 64'd0);
        frame(1'b1, 1);
        check("slot1_x1", {53'd0, seg_x1[21:11]}, 64'd100);
        check("slot1_en", {60'd0, seg_en}, 64'h2);
        check("ready_after_swap", {63'd0, wr_ready}, 64'd1);

        // Out-of-range writes are rejected and leave the table alone
        do_write(1, 100, 50, 1100, 300, 6, 1'b1, 1'b0);
        do_write(3, 0, 768, 0, 0, 2, 1'b1, 1'b0);
        tick(1);
        do_commit();
        frame(1'b1, 1);

        // Write + commit in one cycle, at the coordinate limits
        do_write(2, 0, 0, 1023, 767, 7, 1'b1, 1'b1);
        check("wc_pending", {63'd0, wr_ready}, 64'd0);
        frame(1'b1, 1);

        // Commit coincident with a held frame_start: swap only next frame
        do_write(0, 5, 5, 6, 6, 1, 1'b1, 1'b0);
        do_write(3, 10, 10, 10, 10, 3, 1'b1, 1'b0);
        hcount = 11'd0; vcount = 10'd0;
        tick(1);
        commit_valid = 1'b1;
        tick(1);
        commit_valid = 1'b0;
        tick(3);
        hcount = 11'd5; vcount = 10'd200;
        tick(3);
        check("coincident_pending", {63'd0, commit_ready}, 64'd0);
        check("coincident_no_swap", {60'd0, seg_en}, 64'h6);
        frame(1'b1, 2);
        check("all_enabled", {60'd0, seg_en}, 64'hF);

        // Priority merge
        probe_pixel({3'b000, 3'b111, 3'b010, 3'b000}, 3'b010);
        probe_pixel({3'b011, 3'b111, 3'b010, 3'b001}, 3'b001);
        do_write(1, 100, 50, 400, 300, 5, 1'b0, 1'b1);
        frame(1'b1, 1);
        probe_pixel({3'b000, 3'b111, 3'b010, 3'b000}, 3'b111);
        probe_pixel({3'b011, 3'b000, 3'b010, 3'b000}, 3'b011);
        probe_pixel({3'b000, 3'b000, 3'b010, 3'b000}, 3'b000);

        // Reset while PENDING discards the commit and the shadow table
        do_write(0, 200, 100, 300, 200, 2, 1'b1, 1'b1);
        rst_n = 1'b0;
        clear_model();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        frame(1'b0, 1);
        check("rst_pend_seg_en", {60'd0, seg_en}, 64'd0);
        check("rst_pend_ready", {63'd0, wr_ready}, 64'd1);
        do_commit();
        frame(1'b1, 1);

        tick(2);
        check("swap_q_drained", 64'(swap_q.size()), 64'd0);
        check("err_q_drained", 64'(err_q.size()), 64'd0);
        check("pix_q_drained", 64'(pix_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
